// File: rtl/sssp_ro_arbiter.sv
// sssp_ro_arbiter: picks at most one of three SSSP read-only subtype FIFO
// heads per cycle and issues it to the shared sssp_ro datapath.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid[2:0]     per-subtype FIFO head valid (bit i = subtype i)
//   in_ready[2:0]     per-subtype pop, one-hot or zero
//   in_task           3 x 64 b head task  ({ts[63:32], object[31:0]})
//   in_data           3 x 64 b head data
//   in_cq_slot        3 x 8 b head CQ slot
//   out_valid/ready   issued-task handshake towards the datapath
//   out_task/data/cq_slot/subtype   issued payload
//   rresp_valid/last  memory response beats for this tile's reads
//   outstanding       in-flight read burst count
//   err_underflow     sticky: burst end seen with no burst outstanding
module sssp_ro_arbiter #(
    parameter int TILE_ID         = 0,
    parameter int MAX_OUTSTANDING = 8,
    parameter int STARVE_LIMIT    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   in_valid,
    output logic [2:0]   in_ready,
    input  logic [191:0] in_task,
    input  logic [191:0] in_data,
    input  logic [23:0]  in_cq_slot,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_task,
    output logic [63:0]  out_data,
    output logic [7:0]   out_cq_slot,
    output logic [1:0]   out_subtype,
    input  logic         rresp_valid,
    input  logic         rresp_last,
    output logic [7:0]   outstanding,
    output logic         err_underflow
);

    localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);
    localparam logic [7:0] STARVE  = 8'(STARVE_LIMIT);

    logic        out_valid_q, out_valid_d;
    logic [63:0] out_task_q, out_task_d;
    logic [63:0] out_data_q, out_data_d;
    logic [7:0]  out_slot_q, out_slot_d;
    logic [1:0]  out_sub_q, out_sub_d;
    logic [7:0]  outstanding_q, outstanding_d;
    logic        err_q, err_d;
    logic [7:0]  wait_cnt_q [3];
    logic [7:0]  wait_cnt_d [3];

    logic [2:0]  read_gen;
    logic [2:0]  elig;
    logic [2:0]  starved;
    logic [2:0]  grant;
    logic        stage_free;
    logic        credit_ok;
    logic        inc;
    logic        dec;
    logic [63:0] sel_task;
    logic [63:0] sel_data;
    logic [7:0]  sel_slot;
    logic [1:0]  sel_sub;

    // Selection: starved subtypes first (lowest index), otherwise the
    // deepest eligible subtype so in-flight work drains first.
    always_comb begin
        read_gen[0] = 1'b1;
        // A subtype-1 head with equal halves has zero length: no read.
        read_gen[1] = in_data[127:96] != in_data[95:64];
        read_gen[2] = 1'b0;
        // Checked against the pre-update count, so the limit holds.
        credit_ok  = outstanding_q < MAX_OUT;
        stage_free = !out_valid_q || out_ready;
        for (int i = 0; i < 3; i++) begin
            elig[i]    = in_valid[i] && (!read_gen[i] || credit_ok);
            starved[i] = elig[i] && (wait_cnt_q[i] == STARVE);
        end
        grant = 3'b000;
        if (!rst && stage_free) begin
            if (starved[0])      grant = 3'b001;
            else if (starved[1]) grant = 3'b010;
            else if (starved[2]) grant = 3'b100;
            else if (elig[2])    grant = 3'b100;
            else if (elig[1])    grant = 3'b010;
            else if (elig[0])    grant = 3'b001;
        end
    end

    always_comb begin
        sel_task = '0;
        sel_data = '0;
        sel_slot = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                sel_task = sel_task | in_task[i*64 +: 64];
                sel_data = sel_data | in_data[i*64 +: 64];
                sel_slot = sel_slot | in_cq_slot[i*8 +: 8];
            end
        end
        sel_sub = grant[2] ? 2'd2 : (grant[1] ? 2'd1 : 2'd0);
    end

    // Output stage refills in the same cycle it drains.
    always_comb begin
        out_valid_d = out_valid_q;
        out_task_d  = out_task_q;
        out_data_d  = out_data_q;
        out_slot_d  = out_slot_q;
        out_sub_d   = out_sub_q;
        if (|grant) begin
            out_valid_d = 1'b1;
            out_task_d  = sel_task;
            out_data_d  = sel_data;
            out_slot_d  = sel_slot;
            out_sub_d   = sel_sub;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Credit-blocked heads keep counting so they win once unblocked.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (grant[i] || !in_valid[i])
                wait_cnt_d[i] = 8'd0;
            else if (wait_cnt_q[i] != STARVE)
                wait_cnt_d[i] = wait_cnt_q[i] + 8'd1;
        end
    end

    always_comb begin
        inc           = |(grant & read_gen);
        dec           = rresp_valid && rresp_last;
        outstanding_d = outstanding_q;
        err_d         = err_q;
        if (inc && !dec) begin
            outstanding_d = outstanding_q + 8'd1;
        end else if (dec && !inc) begin
            if (outstanding_q == 8'd0)
                err_d = 1'b1;
            else
                outstanding_d = outstanding_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_task_q    <= '0;
            out_data_q    <= '0;
            out_slot_q    <= '0;
            out_sub_q     <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            for (int i = 0; i < 3; i++)
                wait_cnt_q[i] <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_task_q    <= out_task_d;
            out_data_q    <= out_data_d;
            out_slot_q    <= out_slot_d;
            out_sub_q     <= out_sub_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            for (int i = 0; i < 3; i++)
                wait_cnt_q[i] <= wait_cnt_d[i];
        end
    end

    assign in_ready      = grant;
    assign out_valid     = out_valid_q;
    assign out_task      = out_task_q;
    assign out_data      = out_data_q;
    assign out_cq_slot   = out_slot_q;
    assign out_subtype   = out_sub_q;
    assign outstanding   = outstanding_q;
    assign err_underflow = err_q;

`ifdef XILINX_SIMULATOR
    logic [31:0] cyc_q;
    always_ff @(posedge clk) begin
        if (rst) cyc_q <= '0;
        else     cyc_q <= cyc_q + 32'd1;
    end
    always @(posedge clk) begin
        if (!rst && |grant)
            $display("[%0d] tile %0d issue sub=%0d slot=%0d ts=%0d obj=%0d",
                     cyc_q, TILE_ID, sel_sub, sel_slot,
                     sel_task[63:32], sel_task[31:0]);
    end
`endif

endmodule
